// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel gradient-magnitude core.
//
// Takes raster-order pixels over a valid/ready stream and produces one
// magnitude pixel per input pixel. A frame ends with IMG_W+1 internal pad
// steps that push the last real rows through the window.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    input pixel stream
//   out_valid/out_ready/out_data output magnitude stream (single-entry register)
//   frame_done              pulse on the handshake of the frame's last output
//   busy                    high from the first accepted pixel until frame_done
//
// Build option: define SOBEL_THRESH_EN to binarise interior outputs against
// THRESH. The output becomes all-ones or zero. When the macro is left
// undefined, the core outputs the saturated magnitude.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | accepting input pixels
// FLUSH | feeding IMG_W+1 pad steps so the final centre pixels emerge
// DRAIN | waiting for the last output handshake, then frame_done

module sobel_stream #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = PIX_W + 4;
    localparam int MW = GW + 1;

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              out_valid_q, out_valid_d;
    logic [PIX_W-1:0]  out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              live_q;
    // Two most recent window columns; the third (newest) column is formed
    // from the line-buffer reads and the incoming pixel each step.
    logic [PIX_W-1:0]  win_q [3][2];
    logic [PIX_W-1:0]  win_d [3][2];

    logic [PIX_W-1:0]  lb0_mem [IMG_W];   // previous row
    logic [PIX_W-1:0]  lb1_mem [IMG_W];   // row before that

    logic              avail, in_take, pad_step, step, produce, interior;
    logic              col_last, row_last;
    logic [PIX_W-1:0]  pix_new, rd0, rd1, pix_out;

    // ------------------------------------------------------------------
    // Control: handshakes, counters, state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        busy_d      = busy_q;

        avail      = !out_valid_q || out_ready;
        in_ready   = live_q && (state_q == RUN) && avail;
        in_take    = in_valid && in_ready;
        pad_step   = (state_q == FLUSH) && avail;
        step       = in_take || pad_step;
        pix_new    = in_take ? in_data : '0;
        frame_done = (state_q == DRAIN) && out_valid_q && out_ready;

        col_last = (col_q == CW'(IMG_W - 1));
        row_last = (row_q == RW'(IMG_H - 1));

        if (step) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            RUN:   if (in_take && col_last && row_last) state_d = FLUSH;
            // Pad steps run the counters on from (0,0); the last one is (1,0).
            FLUSH: if (pad_step && row_q == RW'(1) && col_q == '0) state_d = DRAIN;
            DRAIN: if (frame_done) begin
                state_d = RUN;
                col_d   = '0;
                row_d   = '0;
            end
            default: state_d = RUN;
        endcase

        if (frame_done)   busy_d = 1'b0;
        else if (in_take) busy_d = 1'b1;

        // An output exists once the step index reaches IMG_W+1; every pad
        // step corresponds to a border centre pixel.
        produce  = (state_q == FLUSH) || (row_q >= RW'(2)) ||
                   (row_q == RW'(1) && col_q != '0);
        interior = (state_q == RUN) && (row_q >= RW'(2)) && (col_q >= CW'(2));

        out_valid_d = (step && produce) || (out_valid_q && !out_ready);
        out_data_d  = (step && produce) ? pix_out : out_data_q;
    end

    // ------------------------------------------------------------------
    // Window and magnitude
    // ------------------------------------------------------------------
    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        ext = $signed({4'b0000, p});
    endfunction

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        ax, ay;
    logic [MW-1:0]        mag;

    always_comb begin
        rd0 = lb0_mem[col_q];
        rd1 = lb1_mem[col_q];

        win_d = win_q;
        if (step) begin
            for (int i = 0; i < 3; i++) win_d[i][0] = win_q[i][1];
            win_d[0][1] = rd1;
            win_d[1][1] = rd0;
            win_d[2][1] = pix_new;
        end

        // Columns: win_q[.][0] = left, win_q[.][1] = centre, reads/pix_new = right.
        gx = (ext(rd1) + (ext(rd0) <<< 1) + ext(pix_new))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(pix_new))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(rd1));
        ax  = gx[GW-1] ? -gx : gx;
        ay  = gy[GW-1] ? -gy : gy;
        mag = {1'b0, ax} + {1'b0, ay};

        pix_out = '0;
`ifdef SOBEL_THRESH_EN
        if (interior && mag >= MW'(THRESH)) pix_out = '1;
`else
        if (interior) begin
            if (mag > {5'b00000, {PIX_W{1'b1}}}) pix_out = '1;
            else                                  pix_out = mag[PIX_W-1:0];
        end
`endif
    end

`ifndef SOBEL_THRESH_EN
    // THRESH only matters in the binarising build.
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            live_q      <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 2; j++)
                    win_q[i][j] <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            live_q      <= 1'b1;
            win_q       <= win_d;
        end
    end

    // Line-buffer contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (step) begin
            lb1_mem[col_q] <= rd0;
            lb0_mem[col_q] <= pix_new;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sel, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, frame_done, busy;
    logic [7:0] out_data;

    logic       a_in_ready, a_out_valid, a_frame_done, a_busy;
    logic [7:0] a_out_data;
    logic       b_in_ready, b_out_valid, b_frame_done, b_busy;
    logic [7:0] b_out_data;

    sobel_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .THRESH(128)) dut_a (
        .clk(clk), .reset_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_data(a_out_data),
        .frame_done(a_frame_done), .busy(a_busy)
    );

    sobel_stream #(.PIX_W(8), .IMG_W(7), .IMG_H(5), .THRESH(128)) dut_b (
        .clk(clk), .reset_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_data(b_out_data),
        .frame_done(b_frame_done), .busy(b_busy)
    );

    assign in_ready   = sel ? b_in_ready   : a_in_ready;
    assign out_valid  = sel ? b_out_valid  : a_out_valid;
    assign out_data   = sel ? b_out_data   : a_out_data;
    assign frame_done = sel ? b_frame_done : a_frame_done;
    assign busy       = sel ? b_busy       : a_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] pix_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    int         fd_idx[$];
    int         fd_bad, busy_fd_bad, stall_data_bad, stall_ready_bad, stall_full_seen, timeout;
    int         cur_w, cur_h;
    logic [7:0] img [0:63];

    function automatic int px(input int r, input int c);
        return int'(img[r*cur_w + c]);
    endfunction

    function automatic logic [7:0] ref_out(input int r, input int c);
        int gx, gy, mag;
        if (r == 0 || r == cur_h-1 || c == 0 || c == cur_w-1) return 8'd0;
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (mag >= 128) ? 8'd255 : 8'd0;
`else
        return (mag > 255) ? 8'd255 : 8'(mag);
`endif
    endfunction

    // kind: 0 constant 100, 1 ramp col*10, 2 vertical edge, 3 random
    task automatic load_frame(input int kind);
        logic [7:0] v;
        for (int r = 0; r < cur_h; r++)
            for (int c = 0; c < cur_w; c++) begin
                case (kind)
                    0:       v = 8'd100;
                    1:       v = 8'(c*10);
                    2:       v = (c < 2) ? 8'd0 : 8'd255;
                    default: v = 8'($urandom_range(255));
                endcase
                img[r*cur_w + c] = v;
                pix_q.push_back(v);
            end
        for (int r = 0; r < cur_h; r++)
            for (int c = 0; c < cur_w; c++)
                exp_q.push_back(ref_out(r, c));
    endtask

    // Drives pix_q into the selected DUT and records outputs into act_q.
    task automatic run_stream(input int pv, input int pr, input int stall_at,
                              input int stall_len, input int n_out);
        int         cyc = 0;
        int         extra = -1;
        int         stalled = 0;
        logic       stall_now;
        logic       fd_prev = 1'b0;
        logic       held_v = 1'b0;
        logic [7:0] held = 8'd0;
        logic [7:0] dummy;
        fd_idx.delete();
        fd_bad = 0; busy_fd_bad = 0; stall_data_bad = 0;
        stall_ready_bad = 0; stall_full_seen = 0; timeout = 0;
        while (1) begin
            in_valid  = (pix_q.size() > 0) && (int'($urandom_range(99)) < pv);
            in_data   = (pix_q.size() > 0) ? pix_q[0] : 8'h00;
            out_ready = int'($urandom_range(99)) < pr;
            stall_now = (act_q.size() >= stall_at) && (stalled < stall_len);
            if (stall_now) begin
                out_ready = 1'b0;
                stalled++;
            end
            if (extra >= 0) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (fd_prev && busy) busy_fd_bad++;
            fd_prev = frame_done;
            if (frame_done && !(out_valid && out_ready)) fd_bad++;
            if (stall_now && out_valid) begin
                stall_full_seen++;
                if (in_ready) stall_ready_bad++;
                if (held_v && out_data !== held) stall_data_bad++;
                held   = out_data;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (in_valid && in_ready) dummy = pix_q.pop_front();
            if (out_valid && out_ready) begin
                act_q.push_back(out_data);
                if (frame_done) fd_idx.push_back(act_q.size());
            end else if (frame_done) begin
                fd_idx.push_back(-1);
            end
            @(posedge clk); #1;
            cyc++;
            if (extra < 0 && act_q.size() >= n_out) extra = 0;
            else if (extra >= 0) extra++;
            if (extra >= 8) break;
            if (cyc >= 3000) begin
                timeout = 1;
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_assert++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset in_ready: got %0b want 0", in_ready); end
        n_assert++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
        n_assert++; if (out_data !== 8'h00)  begin n_fail++; $display("FAIL reset out_data: got %0d want 0", out_data); end
        n_assert++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %0b want 0", frame_done); end
        n_assert++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset busy: got %0b want 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_patterns;
        logic [7:0] a, e;
        for (int kind = 0; kind < 3; kind++) begin
            sel = 1'b0; cur_w = 4; cur_h = 4;
            act_q.delete(); exp_q.delete();
            load_frame(kind);
            run_stream(100, 100, 1000, 0, 16);
            n_assert++; if (timeout !== 0) begin n_fail++; $display("FAIL pattern%0d timeout: got %0d want 0", kind, timeout); end
            n_assert++; if (act_q.size() !== 16) begin n_fail++; $display("FAIL pattern%0d count: got %0d want 16", kind, act_q.size()); end
            for (int i = 0; i < 16 && act_q.size() > 0; i++) begin
                a = act_q.pop_front();
                e = exp_q.pop_front();
                n_assert++;
                if (a !== e) begin n_fail++; $display("FAIL pattern%0d pix%0d: got %0d want %0d", kind, i, a, e); end
            end
            n_assert++; if (fd_idx.size() !== 1) begin n_fail++; $display("FAIL pattern%0d frame_done count: got %0d want 1", kind, fd_idx.size()); end
            if (fd_idx.size() > 0) begin
                n_assert++; if (fd_idx[0] !== 16) begin n_fail++; $display("FAIL pattern%0d frame_done pos: got %0d want 16", kind, fd_idx[0]); end
            end
            n_assert++; if (busy_fd_bad !== 0) begin n_fail++; $display("FAIL pattern%0d busy after done: got %0d want 0", kind, busy_fd_bad); end
            n_assert++; if (fd_bad !== 0) begin n_fail++; $display("FAIL pattern%0d done w/o handshake: got %0d want 0", kind, fd_bad); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] a, e;
        sel = 1'b0; cur_w = 4; cur_h = 4;
        act_q.delete(); exp_q.delete();
        load_frame(1);
        run_stream(100, 100, 6, 5, 16);
        n_assert++; if (timeout !== 0) begin n_fail++; $display("FAIL bp timeout: got %0d want 0", timeout); end
        n_assert++; if (act_q.size() !== 16) begin n_fail++; $display("FAIL bp count: got %0d want 16", act_q.size()); end
        for (int i = 0; i < 16 && act_q.size() > 0; i++) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_assert++;
            if (a !== e) begin n_fail++; $display("FAIL bp pix%0d: got %0d want %0d", i, a, e); end
        end
        n_assert++; if (stall_full_seen !== 5) begin n_fail++; $display("FAIL bp stalled-full cycles: got %0d want 5", stall_full_seen); end
        n_assert++; if (stall_data_bad !== 0) begin n_fail++; $display("FAIL bp data held: got %0d changes want 0", stall_data_bad); end
        n_assert++; if (stall_ready_bad !== 0) begin n_fail++; $display("FAIL bp in_ready while full: got %0d want 0", stall_ready_bad); end
        n_assert++; if (fd_idx.size() !== 1) begin n_fail++; $display("FAIL bp frame_done count: got %0d want 1", fd_idx.size()); end
    endtask

    task automatic test_random_b2b;
        logic [7:0] a, e;
        sel = 1'b1; cur_w = 7; cur_h = 5;
        act_q.delete(); exp_q.delete();
        load_frame(3);
        load_frame(3);
        run_stream(50, 50, 100000, 0, 70);
        n_assert++; if (timeout !== 0) begin n_fail++; $display("FAIL b2b timeout: got %0d want 0", timeout); end
        n_assert++; if (act_q.size() !== 70) begin n_fail++; $display("FAIL b2b count: got %0d want 70", act_q.size()); end
        for (int i = 0; i < 70 && act_q.size() > 0; i++) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_assert++;
            if (a !== e) begin n_fail++; $display("FAIL b2b pix%0d: got %0d want %0d", i, a, e); end
        end
        n_assert++; if (fd_idx.size() !== 2) begin n_fail++; $display("FAIL b2b frame_done count: got %0d want 2", fd_idx.size()); end
        if (fd_idx.size() == 2) begin
            n_assert++; if (fd_idx[0] !== 35) begin n_fail++; $display("FAIL b2b done0 pos: got %0d want 35", fd_idx[0]); end
            n_assert++; if (fd_idx[1] !== 70) begin n_fail++; $display("FAIL b2b done1 pos: got %0d want 70", fd_idx[1]); end
        end
        n_assert++; if (fd_bad !== 0) begin n_fail++; $display("FAIL b2b done w/o handshake: got %0d want 0", fd_bad); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] a, e;
        int acc = 0;
        int cyc = 0;
        sel = 1'b0; cur_w = 4; cur_h = 4;
        act_q.delete(); exp_q.delete(); pix_q.delete();
        load_frame(1);
        while (acc < 7 && cyc < 200) begin
            in_valid  = 1'b1;
            in_data   = pix_q[0];
            out_ready = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                a = pix_q.pop_front();
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_assert++; if (acc !== 7) begin n_fail++; $display("FAIL midreset accepted: got %0d want 7", acc); end
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset pre out_valid: got %0b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid: got %0b want 0", out_valid); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %0b want 0", busy); end
        in_valid = 1'b0; out_ready = 1'b0;
        pix_q.delete(); exp_q.delete(); act_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_frame(0);
        run_stream(100, 100, 1000, 0, 16);
        n_assert++; if (timeout !== 0) begin n_fail++; $display("FAIL midreset timeout: got %0d want 0", timeout); end
        n_assert++; if (act_q.size() !== 16) begin n_fail++; $display("FAIL midreset count: got %0d want 16", act_q.size()); end
        for (int i = 0; i < 16 && act_q.size() > 0; i++) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_assert++;
            if (a !== e) begin n_fail++; $display("FAIL midreset pix%0d: got %0d want %0d", i, a, e); end
        end
        n_assert++; if (fd_idx.size() !== 1) begin n_fail++; $display("FAIL midreset frame_done count: got %0d want 1", fd_idx.size()); end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_backpressure();
        test_random_b2b();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
